l1_icache_np: RTL and testbench
===============================

L1_ICACHE_NP -- requirements
Module: l1_icache_np

Interface
REQ-001 Parameters (name, default, meaning):
- NPORTS, 2: fetch read ports (1..4).
- WAYS, 8: associativity (power of 2).
- SETS, 128: sets (power of 2).
- LINE_BYTES, 64: line size (power of 2, >=16); BEATS = LINE_BYTES/8.
REQ-002 Derived widths: OFFSET_BITS = log2(LINE_BYTES), INDEX_BITS = log2(SETS), TAG_BITS = 64-OFFSET_BITS-INDEX_BITS.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  NPORTS  per-port fetch request.
- req_addr_i  in  NPORTS*64  per-port physical address; port p at bits [64p+63:64p].
- req_ready_o  out  NPORTS  request accepted this cycle (hit).
- rsp_valid_o  out  NPORTS  response data valid.
- rsp_data_o  out  NPORTS*64  64-bit instruction word.
- flush_i  in  1  invalidate entire cache.
- mem_req_valid_o  out  1  line refill request.
- mem_req_addr_o  out  64  line-aligned refill address.
- mem_req_ready_i  in  1  memory accepts request.
- mem_rsp_valid_i  in  1  refill beat valid.
- mem_rsp_data_i  in  64  refill beat, ascending word order.
- busy_o  out  1  FSM not in IDLE.
- miss_count_o  out  32  refills started, wraps at 2^32.

Function
REQ-004 Lookup per port each cycle: index = addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], tag = addr[63:OFFSET_BITS+INDEX_BITS], word = addr[OFFSET_BITS-1:3]; addr[2:0] ignored.
REQ-005 hit[p] = req_valid_i[p] and any way of the set has valid=1 and a matching tag; a tag shall match at most one valid way.
REQ-006 req_ready_o[p] = hit[p] and state==IDLE, combinational.
REQ-007 Accepted request: rsp_valid_o[p]=1 and rsp_data_o[p] = the addressed word on the next cycle (1-cycle latency); otherwise rsp_valid_o[p]=0 and rsp_data_o[p] holds its last value.
REQ-008 All ports look up independently in the same cycle; there are no bank conflicts.
REQ-009 FSM states: IDLE, REQ, FILL.
REQ-010 IDLE -> REQ: no flush is pending and at least one port has req_valid_i=1 and hit=0. The lowest-index such port wins; its line address and set are captured, a victim = rr_ptr[set] is latched, and miss_count_o increments.
REQ-011 REQ: mem_req_valid_o=1 with the captured line address held stable until mem_req_ready_i=1 -> FILL, beat counter=0.
REQ-012 FILL: each mem_rsp_valid_i writes beat k to word k of the victim way and increments k.
REQ-013 On beat BEATS-1, FILL also writes the tag, sets valid, advances rr_ptr[set] modulo WAYS, and returns to IDLE.
REQ-014 Outside FILL, mem_rsp_valid_i shall be ignored.
REQ-015 During REQ/FILL, req_ready_o is all 0 (blocking cache); requesters hold requests and replay. The first replay after fill completion hits.
REQ-016 The victim way shall be marked invalid when FILL is entered, so partial data is never hit.
REQ-017 flush_i in IDLE clears all valid bits at the clock edge; lookups in that cycle use pre-flush state, and req_ready_o remains combinational on the pre-flush state.
REQ-018 flush_i in REQ/FILL sets flush_pending; the fill completes and is written. On return to IDLE, all valid bits clear and flush_pending clears, taking one cycle with req_ready_o=0 before any new miss is started.
REQ-019 Simultaneous miss and flush_i in IDLE: the flush wins and the miss is not started that cycle.
REQ-020 busy_o = (state != IDLE) or flush_pending.

Reset
REQ-021 rst=1 forces, asynchronously: state=IDLE, all valid bits=0, all rr_ptr=0, beat counter=0, flush_pending=0, miss_count_o=0, rsp_valid_o=0, rsp_data_o=0, mem_req_valid_o=0, mem_req_addr_o=0.
REQ-022 Reset during REQ/FILL abandons the refill with no line validated; beats arriving after reset release are ignored per REQ-014.
REQ-023 The tag and data arrays need not be reset.

Verification
REQ-024 Cold miss: port0 addr 0x1008 after reset -> mem_req_addr_o=0x1000, miss_count_o=1. Feed 8 beats 0xA0..0xA7 -> next cycle port0 ready; one cycle later rsp_data_o[0]=0xA1.
REQ-025 Dual hit: both ports request 0x1000 and 0x1038 after the fill above -> both ready in the same cycle; next cycle data 0xA0 and 0xA7.
REQ-026 Dual miss: port0=0x2000, port1=0x3000, both cold -> port0 refilled first, then port1; miss_count_o increments by 2 total.
REQ-027 Replacement: 9 distinct tags into set 0 -> the 9th evicts way 0 (first-filled line); re-requesting it misses.
REQ-028 Flush mid-fill: assert flush_i at beat 3 -> fill completes, busy_o stays 1 one extra cycle, then the same address misses again.
REQ-029 Reset at beat 5 -> all outputs at reset values; remaining beats ignored; the same address misses afterward.

Source files
------------

// File: rtl/l1_icache_np.sv
// l1_icache_np: blocking multi-port L1 instruction cache. All fetch ports look
// up in parallel; a miss stalls every port while one line is refilled from
// memory into a round-robin victim way.
module l1_icache_np #(
    parameter int NPORTS     = 2,
    parameter int WAYS       = 8,
    parameter int SETS       = 128,
    parameter int LINE_BYTES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0]     req_valid_i,
    input  logic [NPORTS*64-1:0]  req_addr_i,
    output logic [NPORTS-1:0]     req_ready_o,
    output logic [NPORTS-1:0]     rsp_valid_o,
    output logic [NPORTS*64-1:0]  rsp_data_o,
    input  logic                  flush_i,
    output logic                  mem_req_valid_o,
    output logic [63:0]           mem_req_addr_o,
    input  logic                  mem_req_ready_i,
    input  logic                  mem_rsp_valid_i,
    input  logic [63:0]           mem_rsp_data_i,
    output logic                  busy_o,
    output logic [31:0]           miss_count_o
);
    localparam int BEATS       = LINE_BYTES / 8;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int INDEX_BITS  = $clog2(SETS);
    localparam int TAG_BITS    = 64 - OFFSET_BITS - INDEX_BITS;
    localparam int WORD_BITS   = OFFSET_BITS - 3;
    localparam int LINE_BITS   = 64 - OFFSET_BITS;
    localparam int WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
    state_t state_q, state_d;

    logic [SETS-1:0][WAYS-1:0]  valid_q;
    logic [SETS-1:0][WAY_W-1:0] rr_ptr_q;
    logic [TAG_BITS-1:0]        tag_mem  [SETS][WAYS];
    logic [63:0]                data_mem [SETS][WAYS][BEATS];
    logic [WORD_BITS-1:0]       beat_q;
    logic [WAY_W-1:0]           victim_q;
    logic                       flush_pending_q;

    logic [INDEX_BITS-1:0] port_idx  [NPORTS];
    logic [TAG_BITS-1:0]   port_tag  [NPORTS];
    logic [WORD_BITS-1:0]  port_word [NPORTS];
    logic [WAY_W-1:0]      hit_way   [NPORTS];
    logic [NPORTS-1:0]     hit;
    logic [3*NPORTS-1:0]   unused_lsbs;
    logic                  miss_found;
    logic [LINE_BITS-1:0]  miss_line;
    logic                  can_accept;
    logic                  last_beat;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign port_idx[p]          = req_addr_i[64*p+OFFSET_BITS +: INDEX_BITS];
        assign port_tag[p]          = req_addr_i[64*p+OFFSET_BITS+INDEX_BITS +: TAG_BITS];
        assign port_word[p]         = req_addr_i[64*p+3 +: WORD_BITS];
        assign unused_lsbs[3*p +: 3] = req_addr_i[64*p +: 3];
    end

    // The captured refill address doubles as the fill set/tag source.
    assign fill_idx  = mem_req_addr_o[OFFSET_BITS +: INDEX_BITS];
    assign fill_tag  = mem_req_addr_o[63 -: TAG_BITS];
    assign last_beat = mem_rsp_valid_i && (beat_q == WORD_BITS'(BEATS - 1));

    // A pending flush occupies one IDLE cycle in which nothing is accepted.
    assign can_accept      = (state_q == IDLE) && !flush_pending_q;
    assign req_ready_o     = hit & {NPORTS{can_accept}};
    assign mem_req_valid_o = (state_q == REQ);
    assign busy_o          = (state_q != IDLE) || flush_pending_q;

    // Parallel tag compare per port; fills never duplicate a line, so at most one way matches.
    always_comb begin
        hit = '0;
        for (int p = 0; p < NPORTS; p++) begin
            hit_way[p] = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (valid_q[port_idx[p]][w] && (tag_mem[port_idx[p]][w] == port_tag[p])) begin
                    hit[p]     = req_valid_i[p];
                    hit_way[p] = WAY_W'(w);
                end
            end
        end
    end

    // Lowest-index requesting port that misses owns the next refill.
    always_comb begin
        miss_found = 1'b0;
        miss_line  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (!miss_found && req_valid_i[p] && !hit[p]) begin
                miss_found = 1'b1;
                miss_line  = req_addr_i[64*p+OFFSET_BITS +: LINE_BITS];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: flush (requested or pending) blocks a new miss in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!flush_pending_q && !flush_i && miss_found) state_d = REQ;
            REQ:     if (mem_req_ready_i) state_d = FILL;
            FILL:    if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state: valid bits, replacement pointers, refill bookkeeping, responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q         <= '0;
            rr_ptr_q        <= '0;
            beat_q          <= '0;
            victim_q        <= '0;
            flush_pending_q <= 1'b0;
            miss_count_o    <= '0;
            rsp_valid_o     <= '0;
            rsp_data_o      <= '0;
            mem_req_addr_o  <= '0;
        end else begin
            rsp_valid_o <= req_ready_o;
            for (int p = 0; p < NPORTS; p++) begin
                if (req_ready_o[p]) begin
                    rsp_data_o[64*p +: 64] <= data_mem[port_idx[p]][hit_way[p]][port_word[p]];
                end
            end
            if ((state_q != IDLE) && flush_i) flush_pending_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (flush_pending_q || flush_i) begin
                        valid_q         <= '0;
                        flush_pending_q <= 1'b0;
                    end else if (miss_found) begin
                        mem_req_addr_o <= {miss_line, {OFFSET_BITS{1'b0}}};
                        victim_q       <= rr_ptr_q[miss_line[INDEX_BITS-1:0]];
                        miss_count_o   <= miss_count_o + 32'd1;
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        beat_q                      <= '0;
                        valid_q[fill_idx][victim_q] <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_rsp_valid_i) begin
                        beat_q <= beat_q + WORD_BITS'(1);
                        if (last_beat) begin
                            valid_q[fill_idx][victim_q] <= 1'b1;
                            rr_ptr_q[fill_idx] <= (rr_ptr_q[fill_idx] == WAY_W'(WAYS - 1)) ?
                                                  '0 : rr_ptr_q[fill_idx] + WAY_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if ((state_q == FILL) && mem_rsp_valid_i) begin
            data_mem[fill_idx][victim_q][beat_q] <= mem_rsp_data_i;
            if (last_beat) tag_mem[fill_idx][victim_q] <= fill_tag;
        end
    end
endmodule

// File: tb/tb_l1_icache_np.sv
// tb_l1_icache_np: directed and randomized checks of l1_icache_np against a
// line-level residency model (set -> list of resident line addresses).
`timescale 1ns/1ps
module tb_l1_icache_np;
    localparam int NP    = 2;
    localparam int WAYS  = 8;
    localparam int SETS  = 128;
    localparam int LB    = 64;
    localparam int BEATS = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_valid;
    logic [NP*64-1:0]  req_addr;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     rsp_valid;
    logic [NP*64-1:0]  rsp_data;
    logic              flush;
    logic              mem_req_valid;
    logic [63:0]       mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [63:0]       mem_rsp_data;
    logic              busy;
    logic [31:0]       miss_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_line [SETS][WAYS];
    bit          m_val  [SETS][WAYS];
    int          m_rr   [SETS];
    logic [63:0] m_word [logic [63:0]];
    logic [31:0] m_miss;

    always #5 clk = ~clk;

    l1_icache_np #(.NPORTS(NP), .WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LB)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .flush_i(flush),
        .mem_req_valid_o(mem_req_valid), .mem_req_addr_o(mem_req_addr),
        .mem_req_ready_i(mem_req_ready), .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_data_i(mem_rsp_data), .busy_o(busy), .miss_count_o(miss_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return {a[63:6], 6'b0};
    endfunction

    function automatic int set_of(input logic [63:0] a);
        logic [6:0] s;
        s = a[6 +: 7];
        return int'(s);
    endfunction

    function automatic bit resident(input logic [63:0] line);
        int s;
        s = set_of(line);
        for (int w = 0; w < WAYS; w++)
            if (m_val[s][w] && (m_line[s][w] == line)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_install(input logic [63:0] line);
        int s;
        int w;
        s = set_of(line);
        w = m_rr[s];
        m_line[s][w] = line;
        m_val[s][w]  = 1'b1;
        m_rr[s]      = (w + 1) % WAYS;
    endtask

    task automatic m_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
    endtask

    task automatic m_reset();
        m_flush();
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
        m_miss = '0;
    endtask

    // Entered at the negedge after the edge that started a miss; leaves at the
    // negedge after the final beat (or after an aborting reset).
    task automatic do_refill(input logic [63:0] line, input bit rnd, input logic [63:0] base,
                             input int flush_beat, input int reset_beat);
        int          gap;
        logic [63:0] d;
        bit          aborted;
        aborted = 1'b0;
        chk("mreq_vld", 64'(mem_req_valid), 64'd1);
        chk("mreq_addr", mem_req_addr, line);
        chk("miss_cnt", 64'(miss_count), 64'(m_miss));
        chk("busy_req", 64'(busy), 64'd1);
        chk("rdy_req", 64'(req_ready), 64'd0);
        gap = rnd ? int'($urandom_range(0, 2)) : 1;
        for (int i = 0; i < gap; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = {$urandom, $urandom};
            @(negedge clk);
            chk("mreq_hold", mem_req_addr, line);
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("mreq_drop", 64'(mem_req_valid), 64'd0);
        for (int k = 0; k < BEATS; k++) begin
            if (aborted) break;
            if (k == reset_beat) begin
                req_valid = '0;
                #2 rst = 1'b1;
                #1;
                chk("arst_rspv", 64'(rsp_valid), 64'd0);
                chk("arst_rd0", rsp_data[63:0], 64'd0);
                chk("arst_rd1", rsp_data[127:64], 64'd0);
                chk("arst_mreq", 64'(mem_req_valid), 64'd0);
                chk("arst_maddr", mem_req_addr, 64'd0);
                chk("arst_busy", 64'(busy), 64'd0);
                chk("arst_cnt", 64'(miss_count), 64'd0);
                m_reset();
                @(negedge clk);
                rst = 1'b0;
                for (int j = k; j < BEATS; j++) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = {$urandom, $urandom};
                    @(negedge clk);
                end
                mem_rsp_valid = 1'b0;
                aborted = 1'b1;
            end else begin
                if (rnd && ($urandom_range(0, 1) == 1)) begin
                    mem_rsp_valid = 1'b0;
                    @(negedge clk);
                end
                d = rnd ? {$urandom, $urandom} : base + 64'(k);
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = d;
                flush         = (k == flush_beat);
                @(negedge clk);
                mem_rsp_valid = 1'b0;
                flush         = 1'b0;
                m_word[line + 64'(8 * k)] = d;
            end
        end
        if (!aborted) m_install(line);
    endtask

    // Holds each request until accepted, refilling misses as the model predicts.
    task automatic serve(input logic [NP-1:0] v, input logic [63:0] a0, input logic [63:0] a1,
                         input bit rnd, input logic [63:0] base);
        logic [NP-1:0] pend;
        logic [NP-1:0] acc;
        logic [63:0]   a [NP];
        int            miss;
        int            rounds;
        a[0] = a0;
        a[1] = a1;
        pend = v;
        rounds = 0;
        @(negedge clk);
        while ((pend != '0) && (rounds < 8)) begin
            rounds++;
            req_valid = pend;
            req_addr  = {a[1], a[0]};
            #1;
            acc  = '0;
            miss = -1;
            for (int p = 0; p < NP; p++) begin
                if (pend[p]) begin
                    if (resident(line_of(a[p]))) acc[p] = 1'b1;
                    else if (miss < 0) miss = p;
                end
            end
            chk("rdy", 64'(req_ready), 64'(acc));
            chk("busy_idle", 64'(busy), 64'd0);
            chk("mreq_idle", 64'(mem_req_valid), 64'd0);
            if (miss >= 0) m_miss++;
            @(negedge clk);
            chk("rsp_vld", 64'(rsp_valid), 64'(acc));
            for (int p = 0; p < NP; p++)
                if (acc[p]) chk("rsp_data", rsp_data[64*p +: 64], m_word[{a[p][63:3], 3'b0}]);
            pend      = pend & ~acc;
            req_valid = pend;
            if (miss >= 0) do_refill(line_of(a[miss]), rnd, base, -1, -1);
        end
        chk("serve_done", 64'(pend), 64'd0);
        req_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cnt;
        logic [NP-1:0] v;
        logic [63:0] ra [NP];
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        flush = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_rdata", rsp_data[63:0], 64'd0);
        chk("rst_mreq", 64'(mem_req_valid), 64'd0);
        chk("rst_maddr", mem_req_addr, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(miss_count), 64'd0);
        rst = 1'b0;

        // cold miss then 1-cycle hit
        serve(2'b01, 64'h1008, 64'h0, 1'b0, 64'hA0);
        chk("cold_word", rsp_data[63:0], 64'hA1);
        chk("cold_cnt", 64'(miss_count), 64'd1);

        // dual hit in one cycle
        serve(2'b11, 64'h1000, 64'h1038, 1'b0, 64'h0);
        chk("dual_hit0", rsp_data[63:0], 64'hA0);
        chk("dual_hit1", rsp_data[127:64], 64'hA7);

        // dual miss: two refills in port order
        cnt = m_miss;
        serve(2'b11, 64'h2000, 64'h3000, 1'b1, 64'h0);
        chk("dual_miss_cnt", 64'(miss_count), 64'(cnt + 32'd2));

        // flush in IDLE: lookup sees pre-flush state, concurrent miss suppressed
        @(negedge clk);
        req_valid = 2'b11;
        req_addr  = {64'h9000, 64'h1000};
        flush     = 1'b1;
        #1;
        chk("flidle_rdy", 64'(req_ready), 64'd1);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = '0;
        chk("flidle_rsp", 64'(rsp_valid), 64'd1);
        chk("flidle_data", rsp_data[63:0], 64'hA0);
        chk("flidle_nomiss", 64'(mem_req_valid), 64'd0);
        m_flush();
        cnt = m_miss;
        serve(2'b01, 64'h1000, 64'h0, 1'b1, 64'h0);
        chk("flidle_remiss", 64'(miss_count), 64'(cnt + 32'd1));

        // replacement: 9 distinct lines in set 0
        for (int t = 1; t <= 9; t++) serve(2'b01, 64'(t * 32'h2000), 64'h0, 1'b1, 64'h0);
        cnt = m_miss;
        serve(2'b01, 64'h2000, 64'h0, 1'b1, 64'h0);
        chk("evict_miss", 64'(miss_count), 64'(cnt + 32'd1));
        serve(2'b01, 64'h12000, 64'h0, 1'b1, 64'h0);
        chk("evict_keep", 64'(miss_count), 64'(cnt + 32'd1));

        // flush mid-fill
        @(negedge clk);
        req_valid = 2'b01;
        req_addr  = {64'h0, 64'h5000};
        #1;
        chk("fl_cold_rdy", 64'(req_ready), 64'd0);
        m_miss++;
        @(negedge clk);
        do_refill(64'h5000, 1'b0, 64'hF0, 3, -1);
        #1;
        chk("fl_busy", 64'(busy), 64'd1);
        chk("fl_rdy", 64'(req_ready), 64'd0);
        m_flush();
        cnt = m_miss;
        serve(2'b01, 64'h5000, 64'h0, 1'b0, 64'hF8);
        chk("fl_remiss", 64'(miss_count), 64'(cnt + 32'd1));

        // reset at beat 5
        @(negedge clk);
        req_valid = 2'b01;
        req_addr  = {64'h0, 64'h7000};
        #1;
        chk("rs_cold_rdy", 64'(req_ready), 64'd0);
        m_miss++;
        @(negedge clk);
        do_refill(64'h7000, 1'b0, 64'hB0, -1, 5);
        chk("rs_after_mreq", 64'(mem_req_valid), 64'd0);
        chk("rs_after_busy", 64'(busy), 64'd0);
        serve(2'b01, 64'h7000, 64'h0, 1'b0, 64'hC0);
        chk("rs_remiss", 64'(miss_count), 64'd1);

        // randomized traffic over a few sets with overlapping tags
        for (int r = 0; r < 40; r++) begin
            v = NP'($urandom_range(1, 3));
            for (int p = 0; p < NP; p++)
                ra[p] = 64'($urandom_range(0, 11) * 32'h2000 + $urandom_range(0, 3) * 32'd64
                            + $urandom_range(0, 63));
            serve(v, ra[0], ra[1], 1'b1, 64'h0);
        end
        chk("final_cnt", 64'(miss_count), 64'(m_miss));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
